// File: rtl/vga_pkg.sv
// Shared VGA constants and pixel type for the 640x480 pixel-stage blocks.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int RGB_W    = 12;

  typedef logic [RGB_W-1:0] rgb_t;

endpackage

// File: rtl/box_mover.sv
// One axis of the bouncing square: position plus direction bit, reflecting
// off 0 and LIMIT, advancing by STEP on each frame tick while run is high.
module box_mover #(
  parameter int LIMIT = 608,
  parameter int STEP  = 2
) (
  input  logic       pix_clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       run,
  output logic [9:0] pos
);

  localparam logic [10:0] LIMIT_W = 11'(LIMIT);
  localparam logic [10:0] STEP_W  = 11'(STEP);

  logic [9:0]  pos_reg, pos_next;
  logic        dir_reg, dir_next;
  logic [10:0] fwd;

  // 11-bit arithmetic so the forward sum cannot wrap before the limit test.
  assign fwd = {1'b0, pos_reg} + STEP_W;

  always_comb begin
    pos_next = pos_reg;
    dir_next = dir_reg;
    if (tick && run) begin
      if (!dir_reg) begin
        if (fwd >= LIMIT_W) begin
          pos_next = LIMIT_W[9:0];
          dir_next = 1'b1;
        end else begin
          pos_next = fwd[9:0];
        end
      end else if ({1'b0, pos_reg} <= STEP_W) begin
        pos_next = '0;
        dir_next = 1'b0;
      end else begin
        pos_next = pos_reg - STEP_W[9:0];
      end
    end
  end

  always_ff @(posedge pix_clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_reg <= '0;
      dir_reg <= 1'b0;
    end else begin
      pos_reg <= pos_next;
      dir_reg <= dir_next;
    end
  end

  assign pos = pos_reg;

endmodule

// File: rtl/bounce_renderer.sv
// Renders a bouncing solid square over a flat background; colour and syncs
// leave through the same fixed two-register pipeline so they stay aligned.
module bounce_renderer
  import vga_pkg::*;
#(
  parameter int   BOX_SIZE  = 32,
  parameter int   STEP      = 2,
  parameter rgb_t BOX_COLOR = 12'hF80,
  parameter rgb_t BG_COLOR  = 12'h008
) (
  input  logic       pix_clk,
  input  logic       reset_n,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       active,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       run,
  output rgb_t       rgb,
  output logic       hsync_o,
  output logic       vsync_o
);

  localparam int XMAX = H_ACTIVE - BOX_SIZE;
  localparam int YMAX = V_ACTIVE - BOX_SIZE;

  logic       vs_d_reg;
  logic       vs_armed_reg;
  logic       tick;
  logic [9:0] box_pos [2];
  logic [9:0] box_x, box_y;

  // vs_armed_reg blocks a false edge when vsync is already high as reset releases.
  assign tick = vsync & ~vs_d_reg & vs_armed_reg;

  always_ff @(posedge pix_clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_d_reg     <= 1'b0;
      vs_armed_reg <= 1'b0;
    end else begin
      vs_d_reg     <= vsync;
      vs_armed_reg <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      box_mover #(
        .LIMIT ((gi == 0) ? XMAX : YMAX),
        .STEP  (STEP)
      ) u_mover (
        .pix_clk (pix_clk),
        .reset_n (reset_n),
        .tick    (tick),
        .run     (run),
        .pos     (box_pos[gi])
      );
    end
  endgenerate

  assign box_x = box_pos[0];
  assign box_y = box_pos[1];

  logic [10:0] h_ext, v_ext, x_ext, y_ext;
  logic        in_box_next;

  assign h_ext = {1'b0, hcount};
  assign v_ext = {1'b0, vcount};
  assign x_ext = {1'b0, box_x};
  assign y_ext = {1'b0, box_y};
  assign in_box_next = (h_ext >= x_ext) && (h_ext < x_ext + 11'(BOX_SIZE)) &&
                       (v_ext >= y_ext) && (v_ext < y_ext + 11'(BOX_SIZE));

  logic in_box_d1_reg, active_d1_reg, hsync_d1_reg, vsync_d1_reg;
  rgb_t rgb_reg;
  logic hsync_o_reg, vsync_o_reg;

  always_ff @(posedge pix_clk or negedge reset_n) begin
    if (!reset_n) begin
      in_box_d1_reg <= 1'b0;
      active_d1_reg <= 1'b0;
      hsync_d1_reg  <= 1'b0;
      vsync_d1_reg  <= 1'b0;
      rgb_reg       <= '0;
      hsync_o_reg   <= 1'b0;
      vsync_o_reg   <= 1'b0;
    end else begin
      in_box_d1_reg <= in_box_next;
      active_d1_reg <= active;
      hsync_d1_reg  <= hsync;
      vsync_d1_reg  <= vsync;
      rgb_reg       <= !active_d1_reg ? rgb_t'(0) :
                       in_box_d1_reg  ? BOX_COLOR : BG_COLOR;
      hsync_o_reg   <= hsync_d1_reg;
      vsync_o_reg   <= vsync_d1_reg;
    end
  end

  assign rgb     = rgb_reg;
  assign hsync_o = hsync_o_reg;
  assign vsync_o = vsync_o_reg;

endmodule

// File: tb/tb_bounce_renderer.sv
// Scoreboard bench: stimulus pushes hand-derived expectations, a monitor pops
// them two cycles later. A second instance covers clamped reflections.
module tb_bounce_renderer;

  logic       pix_clk;
  logic       reset_n;
  logic [9:0] hcount, vcount;
  logic       active, hsync, vsync, run;
  logic [11:0] rgb, rgb2;
  logic       hsync_o, vsync_o, hs2, vs2;

  bounce_renderer dut (
    .pix_clk (pix_clk), .reset_n (reset_n), .hcount (hcount), .vcount (vcount),
    .active (active), .hsync (hsync), .vsync (vsync), .run (run),
    .rgb (rgb), .hsync_o (hsync_o), .vsync_o (vsync_o)
  );

  // XMAX=240, YMAX=80: every move clamps and both axes flip on the same tick.
  bounce_renderer #(
    .BOX_SIZE (400), .STEP (250), .BOX_COLOR (12'h0F0), .BG_COLOR (12'h008)
  ) dut2 (
    .pix_clk (pix_clk), .reset_n (reset_n), .hcount (hcount), .vcount (vcount),
    .active (active), .hsync (hsync), .vsync (vsync), .run (run),
    .rgb (rgb2), .hsync_o (hs2), .vsync_o (vs2)
  );

  typedef struct {
    logic [11:0] e1;
    logic [11:0] e2;
    logic        hs;
    logic        vs;
    int          due;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ex1 = 0, ey1 = 0, ex2 = 0, ey2 = 0;

  initial pix_clk = 1'b0;
  always #5 pix_clk = ~pix_clk;
  always @(posedge pix_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  function automatic logic [11:0] pix(input int x, y, bx, by, sz, input logic [11:0] col);
    return (x >= bx && x < bx + sz && y >= by && y < by + sz) ? col : 12'h008;
  endfunction

  task automatic drive(input int h, v, input logic act, hs, vs);
    exp_t e;
    hcount = 10'(h); vcount = 10'(v); active = act; hsync = hs; vsync = vs;
    e.e1  = act ? pix(h, v, ex1, ey1, 32, 12'hF80) : 12'h000;
    e.e2  = act ? pix(h, v, ex2, ey2, 400, 12'h0F0) : 12'h000;
    e.hs  = hs;
    e.vs  = vs;
    e.due = cyc + 2;
    e.tag = $sformatf("px(%0d,%0d)", h, v);
    exp_q.push_back(e);
    @(negedge pix_clk);
  endtask

  task automatic probe_at(input int bx, by, sz);
    int px[7];
    int py[7];
    px = '{bx, bx - 1, bx, bx - 1, bx + sz - 1, bx + sz, bx + sz - 1};
    py = '{by, by, by - 1, by - 1, by + sz - 1, by + sz - 1, by + sz};
    for (int i = 0; i < 7; i++)
      if (px[i] >= 0 && px[i] < 640 && py[i] >= 0 && py[i] < 480)
        drive(px[i], py[i], 1'b1, 1'b0, 1'b0);
  endtask

  task automatic probe();
    probe_at(ex1, ey1, 32);
    probe_at(ex2, ey2, 400);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 513, 1'b0, 1'b0, 1'b1);
      drive(0, 514, 1'b0, 1'b0, 1'b1);
      drive(0, 515, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic set_pos(input int x1, y1, x2, y2);
    ex1 = x1; ey1 = y1; ex2 = x2; ey2 = y2;
  endtask

  always @(negedge pix_clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      cur = exp_q.pop_front();
      $display("txn %s rgb=%h rgb2=%h hs=%b vs=%b", cur.tag, rgb, rgb2, hsync_o, vsync_o);
      chk({cur.tag, " rgb"}, rgb, cur.e1);
      chk({cur.tag, " rgb2"}, rgb2, cur.e2);
      chk({cur.tag, " hsync_o"}, {11'd0, hsync_o}, {11'd0, cur.hs});
      chk({cur.tag, " vsync_o"}, {11'd0, vsync_o}, {11'd0, cur.vs});
      chk({cur.tag, " hsync_o2"}, {11'd0, hs2}, {11'd0, cur.hs});
      chk({cur.tag, " vsync_o2"}, {11'd0, vs2}, {11'd0, cur.vs});
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: time %0t reached before completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    reset_n = 1'b0; run = 1'b1;
    hcount = '0; vcount = '0; active = 1'b1; hsync = 1'b1; vsync = 1'b1;
    repeat (3) @(negedge pix_clk);
    chk("reset rgb", rgb, 12'h000);
    chk("reset hsync_o", {11'd0, hsync_o}, 12'h000);
    chk("reset vsync_o", {11'd0, vsync_o}, 12'h000);

    // Release with vsync already high: that pulse must not move the square.
    reset_n = 1'b1;
    drive(0, 0, 1'b1, 1'b1, 1'b1);
    chk("latency cycle1 rgb", rgb, 12'h000);
    repeat (3) drive(0, 0, 1'b1, 1'b0, 1'b0);
    probe();

    for (int h = 636; h <= 692; h++)
      drive(h, 10, h < 640, h >= 688, 1'b0);

    ticks(3);   set_pos(6, 6, 240, 80);   probe();
    run = 1'b0;
    ticks(5);   probe();
    run = 1'b1;
    ticks(221); set_pos(448, 448, 0, 0);  probe();
    ticks(1);   set_pos(450, 446, 240, 80); probe();
    ticks(78);  set_pos(606, 290, 240, 80); probe();
    ticks(1);   set_pos(608, 288, 0, 0);  probe();
    ticks(1);   set_pos(606, 286, 240, 80); probe();
    ticks(143); set_pos(320, 0, 0, 0);    probe();
    ticks(1);   set_pos(318, 2, 240, 80); probe();

    // Mid-frame asynchronous reset.
    hcount = 10'd10; vcount = 10'd200; active = 1'b1; hsync = 1'b1; vsync = 1'b0;
    repeat (3) @(negedge pix_clk);
    chk("pre-reset rgb", rgb, 12'h008);
    chk("pre-reset hsync_o", {11'd0, hsync_o}, 12'h001);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset rgb", rgb, 12'h000);
    chk("async reset rgb2", rgb2, 12'h000);
    chk("async reset hsync_o", {11'd0, hsync_o}, 12'h000);
    @(negedge pix_clk);
    set_pos(0, 0, 0, 0);
    reset_n = 1'b1;
    drive(0, 0, 1'b1, 1'b0, 1'b0);
    probe();
    ticks(1);   set_pos(2, 2, 240, 80);   probe();

    repeat (4) @(negedge pix_clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
